coding_packer_arbiter: RTL

Block-granular round-robin arbiter sharing one coding_output_packer between two code/length producers (e.g. two band encoders).
- Grants one requester for a whole block, delimited by its last flag.
- Forwards code/length words unmodified.
- At block end, drives the packer flush handshake so every block starts word-aligned.
- Sits between the encoder synchronizers and the packer.

---
 rtl/coding_packer_arbiter_pkg.sv | 19 +
 rtl/coding_packer_arbiter_rr.sv | 34 +++
 rtl/coding_packer_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/coding_packer_arbiter_pkg.sv
// Shared types for the block-granular packer arbiter.
// State encoding, empty grant constant and statistics counter type.
package coding_packer_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT0,
    GRANT1,
    FLUSH,
    WAIT
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;

  localparam int STAT_WIDTH_DEF = 16;

  typedef logic [STAT_WIDTH_DEF-1:0] stat_t;

endpackage

// File: rtl/coding_packer_arbiter_rr.sv
// Two-way round-robin grant decision with a registered priority pointer.
// The pointer moves past the requester whose block just ended.
module coding_packer_arbiter_rr
  import coding_packer_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_src,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = GRANT_NONE;
    unique case (1'b1)
      (req == 2'b11): grant = ptr ? 2'b10 : 2'b01;
      (req == 2'b01): grant = 2'b01;
      (req == 2'b10): grant = 2'b10;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (done) begin
      ptr <= ~done_src;
    end
  end

endmodule

// File: rtl/coding_packer_arbiter.sv
// Shares one output packer between two code/length producers, one block at a time.
// Optional statistics counters: define CODING_PACKER_ARBITER_STATS_EN.
module coding_packer_arbiter
  import coding_packer_arbiter_pkg::*;
#(
  parameter int CODE_WIDTH    = 39,
  parameter int BIT_AMT_WIDTH = 6
`ifdef CODING_PACKER_ARBITER_STATS_EN
  ,
  parameter int STAT_WIDTH    = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CODE_WIDTH-1:0]    input_0_code_data,
  input  logic [BIT_AMT_WIDTH-1:0] input_0_length_data,
  input  logic                     input_0_last,
  input  logic                     input_0_valid,
  output logic                     input_0_ready,
  input  logic [CODE_WIDTH-1:0]    input_1_code_data,
  input  logic [BIT_AMT_WIDTH-1:0] input_1_length_data,
  input  logic                     input_1_last,
  input  logic                     input_1_valid,
  output logic                     input_1_ready,
  output logic [CODE_WIDTH-1:0]    output_code_data,
  output logic [BIT_AMT_WIDTH-1:0] output_length_data,
  output logic                     output_valid,
  input  logic                     output_ready,
  output logic                     packer_flush,
  input  logic                     packer_flushed,
  output logic                     grant_source,
  output logic                     block_done
`ifdef CODING_PACKER_ARBITER_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]    stat_words_0,
  output logic [STAT_WIDTH-1:0]    stat_words_1,
  output logic [STAT_WIDTH-1:0]    stat_blocks_0,
  output logic [STAT_WIDTH-1:0]    stat_blocks_1
`endif
);

  state_t     state;
  logic [1:0] grant;
  logic       last_sel;
  logic       xfer;
  logic       blk_end;
  logic       flush_done;

  always_comb begin
    output_code_data   = '0;
    output_length_data = '0;
    output_valid       = 1'b0;
    input_0_ready      = 1'b0;
    input_1_ready      = 1'b0;
    last_sel           = 1'b0;
    unique case (state)
      GRANT0: begin
        output_code_data   = input_0_code_data;
        output_length_data = input_0_length_data;
        output_valid       = input_0_valid;
        input_0_ready      = output_ready;
        last_sel           = input_0_last;
      end
      GRANT1: begin
        output_code_data   = input_1_code_data;
        output_length_data = input_1_length_data;
        output_valid       = input_1_valid;
        input_1_ready      = output_ready;
        last_sel           = input_1_last;
      end
      default: ;
    endcase
  end

  assign xfer       = output_valid & output_ready;
  assign blk_end    = xfer & last_sel;
  assign flush_done = packer_flushed &
                      ((state == FLUSH) | (state == WAIT));

  coding_packer_arbiter_rr u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      ({input_1_valid, input_0_valid}),
    .done     (blk_end),
    .done_src (grant_source),
    .grant    (grant)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      grant_source <= 1'b0;
      packer_flush <= 1'b0;
      block_done   <= 1'b0;
    end else begin
      block_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant != GRANT_NONE) begin
            state        <= grant[1] ? GRANT1 : GRANT0;
            grant_source <= grant[1];
          end
        end
        GRANT0, GRANT1: begin
          if (blk_end) begin
            state        <= FLUSH;
            packer_flush <= 1'b1;
          end
        end
        FLUSH, WAIT: begin
          // flush is held as a level until the packer acknowledges
          if (flush_done) begin
            state        <= IDLE;
            packer_flush <= 1'b0;
            block_done   <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CODING_PACKER_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_words_0  <= '0;
      stat_words_1  <= '0;
      stat_blocks_0 <= '0;
      stat_blocks_1 <= '0;
    end else begin
      if (xfer && !grant_source)
        stat_words_0 <= stat_words_0 + STAT_WIDTH'(1);
      if (xfer && grant_source)
        stat_words_1 <= stat_words_1 + STAT_WIDTH'(1);
      if (flush_done && !grant_source)
        stat_blocks_0 <= stat_blocks_0 + STAT_WIDTH'(1);
      if (flush_done && grant_source)
        stat_blocks_1 <= stat_blocks_1 + STAT_WIDTH'(1);
    end
  end
`endif

endmodule
